// File: rtl/sdram_pll_reset_sequencer_if.sv
// sdram_pll_reset_sequencer_if
//   Signal bundle between the PLL reset sequencer and its surroundings.
//   master : the sequencer (consumes pll_locked / sw_rst_req, drives the rest)
//   slave  : the environment (PLL lock output, software request, reset consumers)
//
//   Signal semantics (no valid/ready pairing on this link):
//     sw_rst_req is a one-refclk-cycle request pulse with no acknowledge; the
//     sequencer samples it on every edge and acts on it in the same edge.
//     pll_locked is asynchronous to refclk; the master resynchronises it.
//     All master outputs are registered and change together with state_o.
//
//   pll_locked  PLL locked indication (async)
//   sw_rst_req  restart request (sync to refclk)
//   pll_rst     PLL reset, active high
//   sdram_rst_n SDRAM controller domain reset, active low
//   sys_rst_n   system domain reset, active low
//   ready       high only while the sequence is complete (RUN)
//   retry_cnt   saturating count of lock timeouts and lock losses
//   state_o     current sequencer state, for debug
//   pll_error   high when the retry limit has been reached (FAIL)
interface sdram_pll_reset_sequencer_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       sdram_rst_n;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [2:0] state_o;
  logic       pll_error;

  modport master (
    input  pll_locked, sw_rst_req,
    output pll_rst, sdram_rst_n, sys_rst_n, ready, retry_cnt, state_o, pll_error
  );

  modport slave (
    output pll_locked, sw_rst_req,
    input  pll_rst, sdram_rst_n, sys_rst_n, ready, retry_cnt, state_o, pll_error
  );
endinterface

// File: rtl/sdram_pll_reset_sequencer.sv
// sdram_pll_reset_sequencer
//   Holds the SDRAM PLL in reset, waits for a lock that stays stable, then
//   releases the SDRAM controller reset followed by the system reset. Any
//   lock loss after the release points (or a software request) re-runs the
//   whole sequence. Runs entirely in the PLL reference clock domain.
//
//   Optional feature macro: PLL_RETRY_LIMIT_EN
//     defined   : after MAX_RETRIES failed attempts the sequencer parks in FAIL
//                 (PLL held in reset, pll_error=1) until rst_n is asserted.
//     undefined : retries continue forever and pll_error is tied low.
//
//   Ports
//     refclk  PLL reference clock, the only clock
//     rst_n   asynchronous active-low reset
//     bus     sdram_pll_reset_sequencer_if.master (see interface header)
module sdram_pll_reset_sequencer #(
  parameter int CNT_W         = 20,
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 270000,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY   = 256,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                        refclk,
  input  logic                        rst_n,
  sdram_pll_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAITLK = 3'd1,
    ST_STABLE = 3'd2,
    ST_SDRAM  = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sdram_rst_n_q, sdram_rst_n_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             pll_error_q, pll_error_d;

  logic [7:0]       retry_inc;
  state_t           retry_state;
  logic             sw_restart;
  logic             restart;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLLRST;
      cnt_q         <= '0;
      retry_q       <= 8'd0;
      pll_rst_q     <= 1'b1;
      sdram_rst_n_q <= 1'b0;
      sys_rst_n_q   <= 1'b0;
      ready_q       <= 1'b0;
      pll_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      sdram_rst_n_q <= sdram_rst_n_d;
      sys_rst_n_q   <= sys_rst_n_d;
      ready_q       <= ready_d;
      pll_error_q   <= pll_error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
`ifdef PLL_RETRY_LIMIT_EN
    // The failed attempt that brings the count to the limit parks in FAIL.
    retry_state = (retry_inc == 8'(MAX_RETRIES)) ? ST_FAIL : ST_PLLRST;
`else
    retry_state = ST_PLLRST;
`endif

    case (state_q)
      ST_PLLRST: if (cnt_q == RST_LAST) state_d = ST_WAITLK;
      ST_WAITLK: begin
        // Lock is tested first so it wins over a simultaneous timeout.
        if (locked_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end
      end
      ST_STABLE: begin
        // A glitch before release is not counted as a retry.
        if (!locked_s_q)                 state_d = ST_WAITLK;
        else if (cnt_q == STABLE_LAST)   state_d = ST_SDRAM;
      end
      ST_SDRAM: begin
        if (!locked_s_q) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s_q) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      ST_FAIL: state_d = ST_FAIL;
`endif
      default: state_d = ST_PLLRST;
    endcase

    // Software restart overrides every other transition; FAIL only exits on rst_n.
    sw_restart = bus.sw_rst_req && (state_q != ST_FAIL);
    if (sw_restart) begin
      state_d = ST_PLLRST;
      retry_d = retry_q;
    end

    // A software restart while already in PLLRST still restarts the hold time.
    restart = sw_restart || (state_d != state_q);
    cnt_d   = restart ? '0 : cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they move with state_o.
  always_comb begin
    pll_rst_d     = 1'b0;
    sdram_rst_n_d = 1'b0;
    sys_rst_n_d   = 1'b0;
    ready_d       = 1'b0;
    pll_error_d   = 1'b0;
    case (state_d)
      ST_PLLRST: pll_rst_d = 1'b1;
      ST_SDRAM:  sdram_rst_n_d = 1'b1;
      ST_RUN: begin
        sdram_rst_n_d = 1'b1;
        sys_rst_n_d   = 1'b1;
        ready_d       = 1'b1;
      end
`ifdef PLL_RETRY_LIMIT_EN
      ST_FAIL: begin
        pll_rst_d   = 1'b1;
        pll_error_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sdram_rst_n = sdram_rst_n_q;
  assign bus.sys_rst_n   = sys_rst_n_q;
  assign bus.ready       = ready_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.state_o     = state_q;
  assign bus.pll_error   = pll_error_q;

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
module tb_sdram_pll_reset_sequencer;
  localparam int CNT_W = 20;
  localparam int RST   = 4;
  localparam int LT    = 16;
  localparam int SC    = 8;
  localparam int SD    = 4;
  localparam int MR    = 2;
  localparam int W     = 16;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  sdram_pll_reset_sequencer_if bus();

  sdram_pll_reset_sequencer #(
    .CNT_W(CNT_W), .RST_CYCLES(RST), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .STAGE_DELAY(SD), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Output word: {state, pll_rst, sdram_rst_n, sys_rst_n, ready, pll_error, retry_cnt}
  function automatic logic [W-1:0] exp_word(input logic [2:0] st, input logic [7:0] rty);
    logic pr, sr, yr, rd, er;
    pr = (st == 3'd0) || (st == 3'd5);
    sr = (st == 3'd3) || (st == 3'd4);
    yr = (st == 3'd4);
    rd = (st == 3'd4);
    er = (st == 3'd5);
    return {st, pr, sr, yr, rd, er, rty};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.state_o, bus.pll_rst, bus.sdram_rst_n, bus.sys_rst_n,
            bus.ready, bus.pll_error, bus.retry_cnt};
  endfunction

  // Clean sequence with lock already present: k edges after the sequence starts.
  function automatic logic [2:0] nominal(input int k);
    if (k < RST)                return 3'd0;
    if (k < RST + 1)            return 3'd1;
    if (k < RST + 1 + SC)       return 3'd2;
    if (k < RST + 1 + SC + SD)  return 3'd3;
    return 3'd4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input logic locked);
    bus.pll_locked = locked;
    bus.sw_rst_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Invariant monitor: sys released implies sdram released; both released implies PLL out of reset.
  always @(negedge refclk) begin
    if (rst_n) begin
      n_checks++;
      if ((bus.sys_rst_n && !bus.sdram_rst_n) || (bus.sys_rst_n && bus.sdram_rst_n && bus.pll_rst)) begin
        n_fail++;
        $display("FAIL invariant at %0t: got pll_rst=%b sdram_rst_n=%b sys_rst_n=%b, required ordered release",
                 $time, bus.pll_rst, bus.sdram_rst_n, bus.sys_rst_n);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    bus.pll_locked = 1'b1;
    bus.sw_rst_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    e = exp_word(3'd0, 8'd0);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", obs_word(), e);
    end
  endtask

  task automatic test_nominal();
    logic [W-1:0] e;
    apply_reset(1'b1);
    for (int c = 1; c <= 24; c++) exp_q.push_back(exp_word(nominal(c), 8'd0));
    for (int c = 1; c <= 24; c++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_word() !== e) begin
        n_fail++;
        $display("FAIL nominal cycle %0d: got %h expected %h", c, obs_word(), e);
      end
    end
  endtask

  task automatic test_no_lock();
    logic [W-1:0] e;
    logic [2:0] st;
    logic [7:0] rty;
    apply_reset(1'b0);
    for (int c = 1; c <= 64; c++) begin
      st  = ((c % (RST + LT)) < RST) ? 3'd0 : 3'd1;
      rty = 8'(c / (RST + LT));
`ifdef PLL_RETRY_LIMIT_EN
      if (c >= 2 * (RST + LT)) begin
        st  = 3'd5;
        rty = 8'(MR);
      end
`endif
      exp_q.push_back(exp_word(st, rty));
    end
    for (int c = 1; c <= 64; c++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_word() !== e) begin
        n_fail++;
        $display("FAIL no_lock cycle %0d: got %h expected %h", c, obs_word(), e);
      end
    end
  endtask

  task automatic test_lock_glitch();
    logic [W-1:0] e;
    apply_reset(1'b1);
    // Lock drops for one cycle while STABLE's counter reads 5; STABLE restarts in full.
    for (int c = 1; c <= 30; c++) begin
      if (c <= 12)       exp_q.push_back(exp_word(nominal(c), 8'd0));
      else if (c == 13)  exp_q.push_back(exp_word(3'd1, 8'd0));
      else               exp_q.push_back(exp_word(nominal(c - 9), 8'd0));
    end
    for (int c = 1; c <= 30; c++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_word() !== e) begin
        n_fail++;
        $display("FAIL lock_glitch cycle %0d: got %h expected %h", c, obs_word(), e);
      end
      if (c == 10) bus.pll_locked = 1'b0;
      if (c == 11) bus.pll_locked = 1'b1;
    end
  endtask

  task automatic test_lock_loss();
    logic [W-1:0] e;
    apply_reset(1'b1);
    for (int c = 1; c <= 44; c++) begin
      if (c <= 22) exp_q.push_back(exp_word(nominal(c), 8'd0));
      else         exp_q.push_back(exp_word(nominal(c - 23), 8'd1));
    end
    for (int c = 1; c <= 44; c++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_word() !== e) begin
        n_fail++;
        $display("FAIL lock_loss cycle %0d: got %h expected %h", c, obs_word(), e);
      end
      if (c == 20) bus.pll_locked = 1'b0;
      if (c == 23) bus.pll_locked = 1'b1;
    end
  endtask

  task automatic test_sw_rst();
    logic [W-1:0] e;
    apply_reset(1'b1);
    // Request and lock loss land together; the request wins, so no retry is counted.
    for (int c = 1; c <= 40; c++) begin
      if (c <= 20) exp_q.push_back(exp_word(nominal(c), 8'd0));
      else         exp_q.push_back(exp_word(nominal(c - 21), 8'd0));
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs_word() !== e) begin
        n_fail++;
        $display("FAIL sw_rst cycle %0d: got %h expected %h", c, obs_word(), e);
      end
      if (c == 20) begin
        bus.sw_rst_req = 1'b1;
        bus.pll_locked = 1'b0;
      end
      if (c == 21) begin
        bus.sw_rst_req = 1'b0;
        bus.pll_locked = 1'b1;
      end
    end
  endtask

  task automatic test_async_abort();
    logic [W-1:0] e;
    apply_reset(1'b1);
    repeat (14) step();
    e = exp_word(3'd3, 8'd0);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL abort_pre: got %h expected %h", obs_word(), e);
    end
    #2 rst_n = 1'b0;
    #1;
    e = exp_word(3'd0, 8'd0);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL abort_async: got %h expected %h", obs_word(), e);
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

`ifdef PLL_RETRY_LIMIT_EN
  task automatic test_fail();
    logic [W-1:0] e;
    apply_reset(1'b0);
    for (int c = 1; c <= 43; c++) begin
      if (c >= 40) exp_q.push_back(exp_word(3'd5, 8'(MR)));
    end
    for (int c = 1; c <= 43; c++) begin
      step();
      if (c >= 40) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_word() !== e) begin
          n_fail++;
          $display("FAIL fail_state cycle %0d: got %h expected %h", c, obs_word(), e);
        end
      end
      if (c == 40) bus.sw_rst_req = 1'b1;
      if (c == 41) bus.sw_rst_req = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    e = exp_word(3'd0, 8'd0);
    n_checks++;
    if (obs_word() !== e) begin
      n_fail++;
      $display("FAIL fail_exit: got %h expected %h", obs_word(), e);
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    test_reset();
    test_nominal();
    test_no_lock();
    test_lock_glitch();
    test_lock_loss();
    test_sw_rst();
    test_async_abort();
`ifdef PLL_RETRY_LIMIT_EN
    test_fail();
`endif
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
